// File: rtl/fetch_queue_if.sv
// fetch_queue_if: ROM request/response, redirect and decode-side dequeue signals of the fetch queue
interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_dout;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              deq_ready;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [CW-1:0]     count;
    modport slave (
        output mem_en, mem_addr, inst_valid, inst, inst_pc, count,
        input  mem_dout, redirect_valid, redirect_pc, deq_ready
    );
    modport master (
        input  mem_en, mem_addr, inst_valid, inst, inst_pc, count,
        output mem_dout, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher feeding a credit-controlled FIFO, flushed by redirects
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  io_fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fl_pc;
    logic              r_inflight;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [31:0]       r_inst_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic              w_redir;
    logic              w_issue;
    logic              w_enq;
    logic              w_deq;

    // count + inflight never exceeds DEPTH, so the sum fits in CW bits
    assign w_redir = io_fq.redirect_valid;
    assign w_issue = rst_n && !w_redir && ((r_count + CW'(r_inflight)) < CW'(DEPTH));
    assign w_enq   = r_inflight && !w_redir;
    assign w_deq   = (r_count != '0) && io_fq.deq_ready && !w_redir;

    assign io_fq.mem_en     = w_issue;
    assign io_fq.mem_addr   = r_pc;
    assign io_fq.inst_valid = (r_count != '0);
    assign io_fq.inst       = r_inst_mem[r_rptr];
    assign io_fq.inst_pc    = r_pc_mem[r_rptr];
    assign io_fq.count      = r_count;

    // Fetch PC and the single outstanding request; a redirect squashes the request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_fl_pc    <= '0;
            r_inflight <= 1'b0;
        end else if (w_redir) begin
            r_pc       <= {io_fq.redirect_pc[ADDR_W-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fl_pc <= r_pc;
                r_pc    <= r_pc + ADDR_W'(4);
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous enqueue and dequeue cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_redir) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + PW'(1);
            if (w_deq) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // FIFO storage: ROM word captured together with the PC that requested it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
        end else if (w_enq) begin
            r_inst_mem[r_wptr] <= io_fq.mem_dout;
            r_pc_mem[r_wptr]   <= r_fl_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios with a scoreboard queue checked by a dequeue monitor
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(32), .DEPTH(4)) bus ();
    fetch_queue_if #(.ADDR_W(32), .DEPTH(4)) bus2 ();

    fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .io_fq(bus.slave));
    fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .io_fq(bus2.slave));

    typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0094_03b3;
            32'd4:   return 32'h0083_8333;
            32'd8:   return 32'h0073_02b3;
            32'd12:  return 32'h0062_8233;
            32'd16:  return 32'h0062_81b3;
            default: return 32'hC0DE_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Synchronous ROMs: data appears the cycle after the request
    always @(posedge clk) if (bus.mem_en) bus.mem_dout <= rom_word(bus.mem_addr);
    always @(posedge clk) bus2.mem_dout <= ~bus2.mem_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc0, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc = pc0 + 32'(4 * i);
            e.w  = rom_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head entry must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.inst_valid && bus.deq_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got pc %0h expected no entry", bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", bus.inst_pc, e.pc);
                check("pop_inst", bus.inst, e.w);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.deq_ready      = 1'b0;
        cyc(2);
        @(negedge clk);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_valid", bus.inst_valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, 0);

        // In-order stream from reset, first entry in cycle 2; wrap of a high RESET_PC
        push(32'h0, 5);
        cyc(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("c0_mem_en", bus.mem_en, 1);
        check("c0_mem_addr", bus.mem_addr, 32'h0);
        check("wrap_addr0", bus2.mem_addr, 32'hFFFF_FFF8);
        cyc(1);
        @(negedge clk);
        check("c1_valid", bus.inst_valid, 0);
        check("wrap_addr1", bus2.mem_addr, 32'hFFFF_FFFC);
        cyc(1);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            check("stream_valid", bus.inst_valid, 1);
            if (k == 2) check("wrap_addr2", bus2.mem_addr, 32'h0000_0000);
            cyc(1);
        end
        check("t1_drained", exp_q.size(), 0);

        // Back-pressure: FIFO fills to DEPTH, issue stops, then drains in order
        rst_n = 1'b0;
        bus.deq_ready = 1'b0;
        cyc(2);
        exp_q.delete();
        push(32'h0, 5);
        rst_n = 1'b1;
        cyc(4);
        @(negedge clk);
        check("credit_stop", bus.mem_en, 0);
        cyc(5);
        @(negedge clk);
        check("full_count", bus.count, 4);
        check("full_mem_en", bus.mem_en, 0);
        check("full_head_pc", bus.inst_pc, 32'h0);
        cyc(1);
        bus.deq_ready = 1'b1;
        cyc(5);
        bus.deq_ready = 1'b0;
        check("t2_drained", exp_q.size(), 0);

        // Redirect coinciding with the response for pc 8
        rst_n = 1'b0;
        bus.deq_ready = 1'b1;
        cyc(2);
        exp_q.delete();
        push(32'h0, 1);
        rst_n = 1'b1;
        cyc(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        check("redir_mem_en", bus.mem_en, 0);
        cyc(1);
        bus.redirect_valid = 1'b0;
        push(32'h40, 2);
        @(negedge clk);
        check("redir_count", bus.count, 0);
        check("redir_valid", bus.inst_valid, 0);
        check("redir_mem_en1", bus.mem_en, 1);
        check("redir_mem_addr", bus.mem_addr, 32'h40);
        cyc(2);
        @(negedge clk);
        check("redir_head_pc", bus.inst_pc, 32'h40);
        cyc(2);
        bus.deq_ready = 1'b0;
        check("t3_drained", exp_q.size(), 0);

        // Back-to-back redirects, last one unaligned
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        cyc(1);
        bus.redirect_pc    = 32'h43;
        @(negedge clk);
        check("b2b_mem_en", bus.mem_en, 0);
        cyc(1);
        bus.redirect_valid = 1'b0;
        bus.deq_ready      = 1'b1;
        push(32'h40, 3);
        @(negedge clk);
        check("align_mem_addr", bus.mem_addr, 32'h40);
        check("b2b_count", bus.count, 0);
        cyc(5);
        bus.deq_ready = 1'b0;
        check("t4_drained", exp_q.size(), 0);

        // Asynchronous reset with three entries queued
        rst_n = 1'b0;
        cyc(2);
        exp_q.delete();
        rst_n = 1'b1;
        cyc(4);
        check("pre_rst_count", bus.count, 3);
        rst_n = 1'b0;
        #1;
        check("async_count", bus.count, 0);
        check("async_valid", bus.inst_valid, 0);
        check("async_mem_en", bus.mem_en, 0);
        bus.deq_ready = 1'b1;
        push(32'h0, 2);
        cyc(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_mem_en", bus.mem_en, 1);
        check("rel_mem_addr", bus.mem_addr, 32'h0);
        cyc(1);
        @(negedge clk);
        check("rel_c1_valid", bus.inst_valid, 0);
        cyc(3);
        bus.deq_ready = 1'b0;
        check("t5_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
